ahb_copy_master: RTL and testbench

//  AHB-Lite initiator driving the CM3 INITEXP0 slave port of the bus matrix. Copies a block of
//  32-bit words from SRC to DST through the system matrix: single NONSEQ read, then single

---
 rtl/ahb_copy_master.sv | 126 ++++++++++++
 tb/tb_ahb_copy_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_copy_master.sv
// AHB-Lite word copy initiator: one NONSEQ read then one NONSEQ write per word, no pipelining.
// Optional fill mode (writes a constant pattern) is enabled by defining AHB_COPY_FILL_EN.
module ahb_copy_master #(
  parameter int          LEN_W     = 16,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             START,
  input  logic [31:0]      SRC_ADDR,
  input  logic [31:0]      DST_ADDR,
  input  logic [LEN_W-1:0] WORD_CNT,
`ifdef AHB_COPY_FILL_EN
  input  logic             FILL,
  input  logic [31:0]      FILL_VAL,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [31:0]      ERR_ADDR,
  output logic             HSEL,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic             HWRITE,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  typedef enum logic [2:0] {S_IDLE, S_RA, S_RD, S_WA, S_WD, S_FIN} state_t;

  state_t             state, state_nxt;
  logic [31:0]        src_q, dst_q, data_q, err_addr_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               err_q, fill_q;
  logic               fill_req;
  logic [31:0]        fill_val;

`ifdef AHB_COPY_FILL_EN
  assign fill_req = FILL;
  assign fill_val = FILL_VAL;
`else
  assign fill_req = 1'b0;
  assign fill_val = 32'h0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (START) begin
        if (WORD_CNT == '0) state_nxt = S_FIN;
        else if (fill_req)  state_nxt = S_WA;
        else                state_nxt = S_RA;
      end
      S_RA:   if (HREADY) state_nxt = S_RD;
      S_RD:   if (HREADY) state_nxt = HRESP ? S_FIN : S_WA;
      S_WA:   if (HREADY) state_nxt = S_WD;
      S_WD:   if (HREADY) begin
        if (HRESP || cnt_q == LEN_W'(1)) state_nxt = S_FIN;
        else if (fill_q)                 state_nxt = S_WA;
        else                             state_nxt = S_RA;
      end
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state, sticky error and the write-data register (visible on HWDATA) are reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
      data_q     <= 32'h0;
      fill_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && START) begin
        err_q  <= 1'b0;
        fill_q <= fill_req;
        if (fill_req) data_q <= fill_val;
      end
      if (state == S_RD && HREADY && !HRESP) data_q <= HRDATA;
      // Error is flagged on the first error cycle; the transfer address is still held.
      if ((state == S_RD || state == S_WD) && HRESP) begin
        err_q      <= 1'b1;
        err_addr_q <= (state == S_RD) ? src_q : dst_q;
      end
    end
  end

  // Job addresses and count carry no reset; they are loaded on every accepted START.
  always_ff @(posedge HCLK) begin
    if (state == S_IDLE && START) begin
      src_q <= {SRC_ADDR[31:2], 2'b00};
      dst_q <= {DST_ADDR[31:2], 2'b00};
      cnt_q <= WORD_CNT;
    end else if (state == S_WD && HREADY && !HRESP) begin
      src_q <= src_q + 32'd4;
      dst_q <= dst_q + 32'd4;
      cnt_q <= cnt_q - LEN_W'(1);
    end
  end

  always_comb begin
    HTRANS    = (state == S_RA || state == S_WA) ? 2'b10 : 2'b00;
    HSEL      = (state == S_RA || state == S_WA);
    HWRITE    = (state == S_WA);
    HADDR     = (state == S_RA) ? src_q : (state == S_WA) ? dst_q : 32'h0;
    HWDATA    = data_q;
    HSIZE     = 3'b010;
    HBURST    = 3'b000;
    HPROT     = HPROT_VAL;
    HMASTLOCK = 1'b0;
    BUSY      = (state != S_IDLE);
    DONE      = (state == S_FIN);
    ERR       = err_q;
    ERR_ADDR  = err_addr_q;
  end

endmodule

// File: tb/tb_ahb_copy_master.sv
// Bench for ahb_copy_master: reactive AHB slave with wait/error injection and a write scoreboard.
module tb_ahb_copy_master;
  localparam int LEN_W = 16;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic             HRESETn, START;
  logic [31:0]      SRC_ADDR, DST_ADDR;
  logic [LEN_W-1:0] WORD_CNT;
`ifdef AHB_COPY_FILL_EN
  logic             FILL;
  logic [31:0]      FILL_VAL;
`endif
  logic             BUSY, DONE, ERR, HSEL, HMASTLOCK, HWRITE;
  logic [31:0]      ERR_ADDR, HADDR, HWDATA;
  logic [1:0]       HTRANS;
  logic [2:0]       HSIZE, HBURST;
  logic [3:0]       HPROT;
  logic [31:0]      HRDATA = 32'h0;
  logic             HREADY = 1'b1;
  logic             HRESP  = 1'b0;

  ahb_copy_master #(.LEN_W(LEN_W), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .START(START),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .WORD_CNT(WORD_CNT),
`ifdef AHB_COPY_FILL_EN
    .FILL(FILL), .FILL_VAL(FILL_VAL),
`endif
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_ADDR(ERR_ADDR),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         sb[$];
  wr_t         e_w;
  logic [31:0] mem [logic [31:0]];

  int          waits = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_at = 32'h0;
  int          nonseq_cnt = 0;
  logic        dp_act = 1'b0, dp_wr = 1'b0, dp_err = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  int          w_left = 0;

  // Slave: one data phase at a time, optional wait states, two-cycle ERROR on a chosen write.
  always @(posedge HCLK) begin
    if (!HRESETn) begin
      HREADY <= 1'b1;
      HRESP  <= 1'b0;
      dp_act <= 1'b0;
    end else begin
      if (dp_act && HREADY && dp_wr && !HRESP) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: unexpected write addr 0x%08h data 0x%08h", dp_addr, HWDATA);
        end else begin
          e_w = sb.pop_front();
          chk("wr_addr", dp_addr, e_w.addr);
          chk("wr_data", HWDATA, e_w.data);
        end
        mem[dp_addr] = HWDATA;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        nonseq_cnt++;
        dp_act  <= 1'b1;
        dp_wr   <= HWRITE;
        dp_addr <= HADDR;
        if (err_en && HWRITE && HADDR == err_at) begin
          dp_err <= 1'b1;
          HREADY <= 1'b0;
          HRESP  <= 1'b1;
        end else begin
          dp_err <= 1'b0;
          HRESP  <= 1'b0;
          HRDATA <= mem.exists(HADDR) ? mem[HADDR] : 32'h0;
          w_left <= waits;
          HREADY <= (waits == 0);
        end
      end else if (dp_act && !HREADY) begin
        if (dp_err) HREADY <= 1'b1;
        else begin
          if (dp_wr && sb.size() > 0) chk("hwdata_wait", HWDATA, sb[0].data);
          if (HTRANS != 2'b00) chk("htrans_wait", {30'h0, HTRANS}, 32'h0);
          w_left <= w_left - 1;
          if (w_left == 1) HREADY <= 1'b1;
        end
      end else begin
        dp_act <= 1'b0;
        HREADY <= 1'b1;
        HRESP  <= 1'b0;
      end
    end
  end

  // Returns the cycle (1 = first cycle after the START edge) in which DONE was seen, -1 on timeout.
  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                         output int cyc, output logic busy_at_done);
    @(negedge HCLK);
    START = 1'b1; SRC_ADDR = s; DST_ADDR = d; WORD_CNT = LEN_W'(n);
    @(negedge HCLK);
    START = 1'b0;
    cyc = 1;
    while (!DONE && cyc < 300) begin
      @(negedge HCLK);
      cyc++;
    end
    busy_at_done = BUSY;
    if (!DONE) cyc = -1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_htrans"}, {30'h0, HTRANS}, 32'h0);
    chk({pfx, "_hsel"},   {31'h0, HSEL},   32'h0);
    chk({pfx, "_hwrite"}, {31'h0, HWRITE}, 32'h0);
    chk({pfx, "_haddr"},  HADDR,           32'h0);
    chk({pfx, "_hwdata"}, HWDATA,          32'h0);
    chk({pfx, "_busy"},   {31'h0, BUSY},   32'h0);
    chk({pfx, "_done"},   {31'h0, DONE},   32'h0);
    chk({pfx, "_err"},    {31'h0, ERR},    32'h0);
    chk({pfx, "_erraddr"}, ERR_ADDR,       32'h0);
  endtask

  int   cyc, ns0, done_seen, busy_seen;
  logic bad;

  initial begin
    HRESETn = 1'b0; START = 1'b0; SRC_ADDR = '0; DST_ADDR = '0; WORD_CNT = '0;
`ifdef AHB_COPY_FILL_EN
    FILL = 1'b0; FILL_VAL = '0;
`endif
    repeat (3) @(negedge HCLK);
    chk_reset_outputs("rst");
    chk("hsize",  {29'h0, HSIZE},  32'h2);
    chk("hburst", {29'h0, HBURST}, 32'h0);
    chk("hprot",  {28'h0, HPROT},  32'h3);
    chk("hlock",  {31'h0, HMASTLOCK}, 32'h0);
    HRESETn = 1'b1;

    // Basic copy, zero wait states.
    mem[32'h2000_0000] = 32'h11; mem[32'h2000_0004] = 32'h22; mem[32'h2000_0008] = 32'h33;
    for (int i = 0; i < 3; i++) sb.push_back('{32'h2000_0100 + 32'(4*i), 32'h11 * 32'(i+1)});
    ns0 = nonseq_cnt;
    run_job(32'h2000_0000, 32'h2000_0100, 3, cyc, bad);
    chk("t1_done_cyc", cyc, 13);
    chk("t1_busy_done", {31'h0, bad}, 32'h1);
    chk("t1_err", {31'h0, ERR}, 32'h0);
    chk("t1_nonseq", nonseq_cnt - ns0, 6);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_mem2", mem[32'h2000_0108], 32'h33);

    // Two wait states on each data phase, unaligned address bits ignored.
    waits = 2;
    mem[32'h2000_0040] = 32'hA5A5_0001; mem[32'h2000_0044] = 32'h5A5A_0002; mem[32'h2000_0048] = 32'hFFFF_0003;
    sb.push_back('{32'h2000_0200, 32'hA5A5_0001});
    sb.push_back('{32'h2000_0204, 32'h5A5A_0002});
    sb.push_back('{32'h2000_0208, 32'hFFFF_0003});
    run_job(32'h2000_0043, 32'h2000_0202, 3, cyc, bad);
    chk("t2_done_cyc", cyc, 25);
    chk("t2_sb_empty", sb.size(), 0);
    waits = 0;

    // Zero-length job: FIN only.
    ns0 = nonseq_cnt;
    run_job(32'h2000_0000, 32'h2000_0100, 0, cyc, bad);
    chk("t3_done_cyc", cyc, 1);
    chk("t3_busy_done", {31'h0, bad}, 32'h1);
    @(negedge HCLK);
    chk("t3_busy_after", {31'h0, BUSY}, 32'h0);
    chk("t3_done_after", {31'h0, DONE}, 32'h0);
    chk("t3_nonseq", nonseq_cnt - ns0, 0);

    // Error on the second write.
    err_en = 1'b1; err_at = 32'h2000_0104;
    sb.push_back('{32'h2000_0100, 32'h11});
    ns0 = nonseq_cnt;
    run_job(32'h2000_0000, 32'h2000_0100, 3, cyc, bad);
    chk("t4_done_cyc", cyc, 10);
    chk("t4_err", {31'h0, ERR}, 32'h1);
    chk("t4_err_addr", ERR_ADDR, 32'h2000_0104);
    repeat (3) @(negedge HCLK);
    chk("t4_nonseq", nonseq_cnt - ns0, 4);
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_err_sticky", {31'h0, ERR}, 32'h1);
    err_en = 1'b0;
    sb.push_back('{32'h2000_0300, 32'h11});
    run_job(32'h2000_0000, 32'h2000_0300, 1, cyc, bad);
    chk("t4_next_cyc", cyc, 5);
    chk("t4_err_clr", {31'h0, ERR}, 32'h0);

    // START while busy is ignored; reset mid-read aborts silently.
    waits = 3;
    ns0 = nonseq_cnt;
    @(negedge HCLK);
    START = 1'b1; SRC_ADDR = 32'h2000_0000; DST_ADDR = 32'h2000_0400; WORD_CNT = 2;
    @(negedge HCLK);
    START = 1'b0;
    @(negedge HCLK);
    START = 1'b1; WORD_CNT = 0;
    @(negedge HCLK);
    START = 1'b0;
    chk("t5_busy", {31'h0, BUSY}, 32'h1);
    chk("t5_done", {31'h0, DONE}, 32'h0);
    chk("t5_haddr_idle", HADDR, 32'h0);
    HRESETn = 1'b0;
    @(negedge HCLK);
    chk_reset_outputs("t5");
    HRESETn = 1'b1;
    done_seen = 0; busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (DONE) done_seen++;
      if (BUSY) busy_seen++;
    end
    chk("t5_no_done", done_seen, 0);
    chk("t5_no_busy", busy_seen, 0);
    chk("t5_nonseq", nonseq_cnt - ns0, 1);
    waits = 0;

`ifdef AHB_COPY_FILL_EN
    // Fill mode with address wrap.
    FILL = 1'b1; FILL_VAL = 32'hDEAD_BEEF;
    sb.push_back('{32'hFFFF_FFF8, 32'hDEAD_BEEF});
    sb.push_back('{32'hFFFF_FFFC, 32'hDEAD_BEEF});
    sb.push_back('{32'h0000_0000, 32'hDEAD_BEEF});
    ns0 = nonseq_cnt;
    run_job(32'h1234_5678, 32'hFFFF_FFF8, 3, cyc, bad);
    FILL = 1'b0;
    chk("t6_done_cyc", cyc, 7);
    chk("t6_nonseq", nonseq_cnt - ns0, 3);
    chk("t6_sb_empty", sb.size(), 0);
`endif

    @(negedge HCLK);
    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
